// File: rtl/serial_sorter.sv
// Streaming insertion sorter: words arrive serially, are inserted into a sorted
// register array, and leave serially in ascending order.
module serial_sorter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] slot_q [N];
  logic [DW-1:0] slot_d [N];
  logic [N-1:0]  vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          pop;

  assign accept = in_valid && (state_q == LOAD);
  assign pop    = out_ready && (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N; i++) slot_d[i] = slot_q[i];

    if (accept) begin
      // Every slot decides independently: shift up, take the new word, or hold.
      if (in_data < slot_q[0] || !vld_q[0]) slot_d[0] = in_data;
      for (int i = 1; i < N; i++) begin
        if (vld_q[i-1] && (in_data < slot_q[i-1])) slot_d[i] = slot_q[i-1];
        else if ((in_data < slot_q[i]) || !vld_q[i]) slot_d[i] = in_data;
      end
      vld_d = {vld_q[N-2:0], 1'b1};
      cnt_d = cnt_q + 1'b1;
      if ((cnt_q == CW'(N - 1)) || in_last) state_d = DRAIN;
    end else if (pop) begin
      for (int i = 0; i < N - 1; i++) slot_d[i] = slot_q[i+1];
      slot_d[N-1] = '0;
      vld_d = {1'b0, vld_q[N-1:1]};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) state_d = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      vld_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < N; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = slot_q[0];
  assign out_last  = (state_q == DRAIN) && (cnt_q == CW'(1));

endmodule
